hazard_controller: RTL and testbench

Central ID-stage stall/flush controller for the 5-stage MIPS pipeline. It merges load-use, branch-operand and multiply/divide hazards into one set of pipeline-register controls. It also sequences the multi-cycle MDU: issues the start pulse, tracks busy time with a counter and strobes the HI/LO write. It sits beside the ID stage and drives the PC, IF/ID and ID/EX register enables and flushes.

---
 rtl/hazard_controller.sv | 128 ++++++++++++
 tb/tb_hazard_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// ID-stage stall/flush controller with multi-cycle MDU sequencing.
// Optional HAZARD_STATS_EN adds a saturating stall_cycles counter output.
module hazard_controller #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 16,
    parameter int CNT_W       = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [4:0]   id_Ra,
    input  logic [4:0]   id_Rb,
    input  logic         id_UseRb,
    input  logic [2:0]   id_Branch,
    input  logic         id_BranchTaken,
    input  logic         id_MduStart,
    input  logic         id_MduDiv,
    input  logic         id_MduRead,
    input  logic         ex_RegWr,
    input  logic         ex_MemtoReg,
    input  logic [4:0]   ex_Rw,
    input  logic         mem_MemtoReg,
    input  logic [4:0]   mem_Rw,
    output logic         PCWr,
    output logic         IFIDWr,
    output logic         IFIDFlush,
    output logic         IDEXFlush,
    output logic [1:0]   stall_cause,
    output logic         mdu_start,
    output logic         mdu_busy,
    output logic         mdu_hilo_wr
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]  stall_cycles
`endif
);

    typedef enum logic {RUN, BUSY} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic ex_ra_hit, ex_rb_hit, mem_ra_hit, mem_rb_hit;
    logic two_op_branch;
    logic load_use, branch_haz, mdu_haz, stall;

    // Register 0 is excluded by requiring a nonzero destination.
    always_comb begin
        ex_ra_hit     = (ex_Rw != '0) && (ex_Rw == id_Ra);
        ex_rb_hit     = (ex_Rw != '0) && (ex_Rw == id_Rb);
        mem_ra_hit    = (mem_Rw != '0) && (mem_Rw == id_Ra);
        mem_rb_hit    = (mem_Rw != '0) && (mem_Rw == id_Rb);
        two_op_branch = (id_Branch == 3'b001) || (id_Branch == 3'b010);

        load_use   = ex_MemtoReg && (ex_ra_hit || (id_UseRb && ex_rb_hit));
        branch_haz = (id_Branch != 3'b000) &&
                     ((ex_RegWr    && (ex_ra_hit  || (two_op_branch && ex_rb_hit))) ||
                      (mem_MemtoReg && (mem_ra_hit || (two_op_branch && mem_rb_hit))));
        mdu_busy   = !reset && (state_q == BUSY);
        mdu_haz    = (id_MduStart || id_MduRead) && mdu_busy;
        stall      = !reset && (load_use || branch_haz || mdu_haz);
    end

    always_comb begin
        PCWr        = 1'b1;
        IFIDWr      = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXFlush   = 1'b0;
        stall_cause = 2'b00;
        if (stall) begin
            PCWr      = 1'b0;
            IFIDWr    = 1'b0;
            IDEXFlush = 1'b1;
            if (load_use)
                stall_cause = 2'b01;
            else if (branch_haz)
                stall_cause = 2'b10;
            else
                stall_cause = 2'b11;
        end else if (!reset) begin
            IFIDFlush = id_BranchTaken;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mdu_start   = 1'b0;
        mdu_hilo_wr = 1'b0;
        case (state_q)
            RUN: begin
                if (id_MduStart && !stall && !reset) begin
                    mdu_start = 1'b1;
                    state_d   = BUSY;
                    cnt_d     = id_MduDiv ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    mdu_hilo_wr = !reset;
                    state_d     = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= '0;
        else if (stall && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: vector table for the hazard
// logic plus directed MDU and reset sequences.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_Ra, id_Rb, ex_Rw, mem_Rw;
    logic        id_UseRb, id_BranchTaken, id_MduStart, id_MduDiv, id_MduRead;
    logic [2:0]  id_Branch;
    logic        ex_RegWr, ex_MemtoReg, mem_MemtoReg;
    logic        PCWr, IFIDWr, IFIDFlush, IDEXFlush;
    logic [1:0]  stall_cause;
    logic        mdu_start, mdu_busy, mdu_hilo_wr;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_controller #(.MULT_CYCLES(4), .DIV_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .id_Ra(id_Ra), .id_Rb(id_Rb), .id_UseRb(id_UseRb),
        .id_Branch(id_Branch), .id_BranchTaken(id_BranchTaken),
        .id_MduStart(id_MduStart), .id_MduDiv(id_MduDiv), .id_MduRead(id_MduRead),
        .ex_RegWr(ex_RegWr), .ex_MemtoReg(ex_MemtoReg), .ex_Rw(ex_Rw),
        .mem_MemtoReg(mem_MemtoReg), .mem_Rw(mem_Rw),
        .PCWr(PCWr), .IFIDWr(IFIDWr), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
        .stall_cause(stall_cause), .mdu_start(mdu_start), .mdu_busy(mdu_busy),
        .mdu_hilo_wr(mdu_hilo_wr)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    typedef struct {
        logic [4:0] ra;
        logic [4:0] rb;
        logic       use_rb;
        logic [2:0] br;
        logic       taken;
        logic       ex_regwr;
        logic       ex_mem;
        logic [4:0] ex_rw;
        logic       mem_mem;
        logic [4:0] mem_rw;
        logic       pcwr;
        logic       ifidwr;
        logic       ifidflush;
        logic       idexflush;
        logic [1:0] cause;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_Ra = '0; id_Rb = '0; id_UseRb = 1'b0; id_Branch = '0; id_BranchTaken = 1'b0;
        id_MduStart = 1'b0; id_MduDiv = 1'b0; id_MduRead = 1'b0;
        ex_RegWr = 1'b0; ex_MemtoReg = 1'b0; ex_Rw = '0;
        mem_MemtoReg = 1'b0; mem_Rw = '0;
    endtask

    task automatic check_ctrl(input string tag, input logic pcwr, input logic ifidwr,
                              input logic ifidflush, input logic idexflush, input logic [1:0] cause);
        check({tag, ".PCWr"}, 32'(PCWr), 32'(pcwr));
        check({tag, ".IFIDWr"}, 32'(IFIDWr), 32'(ifidwr));
        check({tag, ".IFIDFlush"}, 32'(IFIDFlush), 32'(ifidflush));
        check({tag, ".IDEXFlush"}, 32'(IDEXFlush), 32'(idexflush));
        check({tag, ".stall_cause"}, 32'(stall_cause), 32'(cause));
    endtask

    task automatic check_mdu(input string tag, input logic start, input logic busy, input logic hilo);
        check({tag, ".mdu_start"}, 32'(mdu_start), 32'(start));
        check({tag, ".mdu_busy"}, 32'(mdu_busy), 32'(busy));
        check({tag, ".mdu_hilo_wr"}, 32'(mdu_hilo_wr), 32'(hilo));
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (mdu_busy && k < 40) begin
            tick();
            k++;
        end
        check({tag, ".idle_timeout"}, 32'(mdu_busy), 32'd0);
    endtask

    initial begin
        //            ra     rb    urb  br      tk   exw  exm  exrw   mm   memrw  pc   ifw  iff  idf  cause
        vecs[0]  = '{5'd8, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
        vecs[1]  = '{5'd0, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[2]  = '{5'd0, 5'd7, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
        vecs[3]  = '{5'd0, 5'd7, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[4]  = '{5'd2, 5'd9, 1'b1, 3'b001, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
        vecs[5]  = '{5'd2, 5'd9, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10};
        vecs[6]  = '{5'd2, 5'd9, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00};
        vecs[7]  = '{5'd3, 5'd5, 1'b0, 3'b101, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[8]  = '{5'd5, 5'd0, 1'b0, 3'b101, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10};
        vecs[9]  = '{5'd4, 5'd0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10};
        vecs[10] = '{5'd4, 5'd0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[11] = '{5'd0, 5'd0, 1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[12] = '{5'd2, 5'd9, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[13] = '{5'd6, 5'd0, 1'b0, 3'b001, 1'b1, 1'b1, 1'b1, 5'd6, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
        vecs[14] = '{5'd3, 5'd0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10};

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        check_ctrl("reset", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        check_mdu("reset", 1'b0, 1'b0, 1'b0);
        // A pending start must not issue while reset is held.
        id_MduStart = 1'b1;
        #1;
        check("reset.start_blocked", 32'(mdu_start), 32'd0);
        id_MduStart = 1'b0;
`ifdef HAZARD_STATS_EN
        check("reset.stall_cycles", stall_cycles, 32'd0);
`endif
        tick();
        reset = 1'b0;

        foreach (vecs[i]) begin
            id_Ra = vecs[i].ra; id_Rb = vecs[i].rb; id_UseRb = vecs[i].use_rb;
            id_Branch = vecs[i].br; id_BranchTaken = vecs[i].taken;
            ex_RegWr = vecs[i].ex_regwr; ex_MemtoReg = vecs[i].ex_mem; ex_Rw = vecs[i].ex_rw;
            mem_MemtoReg = vecs[i].mem_mem; mem_Rw = vecs[i].mem_rw;
            #1;
            check_ctrl($sformatf("vec%0d", i), vecs[i].pcwr, vecs[i].ifidwr,
                       vecs[i].ifidflush, vecs[i].idexflush, vecs[i].cause);
            check_mdu($sformatf("vec%0d", i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle_inputs();

        // MDU read with nothing in flight proceeds.
        id_MduRead = 1'b1;
        #1;
        check_ctrl("mfhi_idle", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        tick();

        // Multiply at T, mfhi in ID from T+1 until it proceeds at T+5.
        id_MduRead = 1'b0; id_MduStart = 1'b1; id_MduDiv = 1'b0;
        #1;
        check_mdu("mult.T", 1'b1, 1'b0, 1'b0);
        check_ctrl("mult.T", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        tick();
        id_MduStart = 1'b0; id_MduRead = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check_mdu($sformatf("mult.T%0d", k), 1'b0, 1'b1, k == 4);
            check_ctrl($sformatf("mult.T%0d", k), 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
            tick();
        end
        #1;
        check_mdu("mult.T5", 1'b0, 1'b0, 1'b0);
        check_ctrl("mult.T5", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        tick();
        idle_inputs();

        // Divide at T with a second start held in ID: it issues at T+17.
        id_MduStart = 1'b1; id_MduDiv = 1'b1;
        #1;
        check_mdu("div.T", 1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 1; k <= 16; k++) begin
            #1;
            check_mdu($sformatf("div.T%0d", k), 1'b0, 1'b1, k == 16);
            check("div.cause", 32'(stall_cause), 32'd3);
            tick();
        end
        #1;
        check_mdu("div.T17", 1'b1, 1'b0, 1'b0);
        check_ctrl("div.T17", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        tick();
        id_MduStart = 1'b0;
        #1;
        check("div2.busy", 32'(mdu_busy), 32'd1);
        wait_idle("div2");
        tick();

        // Reset at the third busy cycle of a divide.
        id_MduStart = 1'b1; id_MduDiv = 1'b1;
        #1;
        check("rdiv.start", 32'(mdu_start), 32'd1);
        tick();
        id_MduStart = 1'b0;
        #1;
        check("rdiv.busy1", 32'(mdu_busy), 32'd1);
        tick();
        tick();
        reset = 1'b1; id_MduStart = 1'b1;
        #1;
        check_mdu("rdiv.in_reset", 1'b0, 1'b0, 1'b0);
        check_ctrl("rdiv.in_reset", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        tick();
        reset = 1'b0;
        #1;
        check_mdu("rdiv.after", 1'b1, 1'b0, 1'b0);
        tick();
        id_MduStart = 1'b0;
        #1;
        check("rdiv.reissue_busy", 32'(mdu_busy), 32'd1);
        wait_idle("rdiv");
        tick();
        idle_inputs();

`ifdef HAZARD_STATS_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ex_MemtoReg = 1'b1; ex_Rw = 5'd8; id_Ra = 5'd8;
        tick();
        tick();
        tick();
        idle_inputs();
        tick();
        check("stats.three", stall_cycles, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
